pipe_mux_n_to_1: RTL and testbench
==================================

Name: pipe_mux_n_to_1

Overview:
- Parametrised N-input, DATA_W-bit selector with a registered 2-entry skid buffer and a valid/ready handshake on both sides.
- Replaces bare combinational 2:1 muxes on datapath boundaries that need pipelining, for example the writeback-result select feeding the register file across a stall-capable stage.
- An out-of-range select produces a defined zero and sets a sticky error flag; it never produces X.

Parameters:
- DATA_W, 32: width of each data input and of Mux_Out.
- N_IN, 4: number of data inputs. Legal range 2..16.
- SEL_W, 2: width of Sel. Must satisfy 2**SEL_W >= N_IN; an elaboration-time check stops the build otherwise.

Ports:
- Clk, input, 1: single clock, rising edge.
- Reset, input, 1: synchronous, active-high reset.
- In_Bus, input, DATA_W*N_IN: packed inputs. Input k occupies bits [k*DATA_W +: DATA_W].
- Sel, input, SEL_W: input index, sampled only on an accepted beat.
- In_Valid, input, 1: upstream beat present.
- In_Ready, output, 1: buffer can accept a beat this cycle.
- Flush, input, 1: discards all buffered beats.
- Mux_Out, output, DATA_W: head-of-buffer data.
- Out_Valid, output, 1: Mux_Out holds a valid beat.
- Out_Ready, input, 1: downstream accepts the head beat.
- Sel_Err, output, 1: sticky flag, set when an out-of-range Sel was accepted.
- Err_Cnt, output, 8: count of accepted out-of-range selects (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock: Clk.
  - Reset is synchronous and active-high; all state changes only on the rising edge of Clk.
- Reset values:
  - Buffer count = 0 and read/write pointers = 0.
  - Out_Valid = 0, Mux_Out = 0, Sel_Err = 0, Err_Cnt = 0.
  - In_Ready = 0 while Reset is high. It is 1 in the first cycle after Reset deasserts.
  - Reset asserted mid-transfer drops all buffered beats, with no output beat.
- Storage:
  - Two entries of DATA_W bits.
  - 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- Push:
  - Occurs when In_Valid && In_Ready && !Flush.
  - The written value is In_Bus slice [Sel] if Sel < N_IN, else 0.
- Pop:
  - Occurs when Out_Valid && Out_Ready && !Flush.
- Handshake outputs:
  - In_Ready = !Reset && (count != 2). It is a function of registered state only; there is no combinational path from Out_Ready.
  - Out_Valid = (count != 0).
  - Mux_Out = entry[rd_ptr] when Out_Valid = 1, else 0.
- Latency:
  - A beat accepted at edge t into an empty buffer is visible on Mux_Out/Out_Valid after edge t.
  - This is one cycle of latency.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
- Full (count = 2): In_Ready = 0. In_Valid is ignored and upstream must hold its beat.
- Empty (count = 0): no pop is possible and Out_Ready is ignored.
- Wrap-around: both pointers toggle 1 -> 0.
- Ordering: beats leave strictly in acceptance order. No drop or duplication except on Flush or Reset.
- Upstream stability: upstream must hold In_Bus/Sel/In_Valid stable while In_Valid && !In_Ready.
- Flush:
  - At the next edge, count = 0 and pointers = 0.
  - A same-cycle push or pop is discarded.
  - Sel_Err and Err_Cnt are not affected.
- Reset vs Flush: Reset has priority over Flush.
- Select error:
  - An accepted push with Sel >= N_IN sets Sel_Err at that edge.
  - Sel_Err stays set until Reset.
  - Out-of-range Sel on a non-accepted cycle has no effect.

Optional Feature:
- Macro: MUX_ERR_CNT_EN.
- When defined:
  - Err_Cnt increments by 1 on every accepted push with Sel >= N_IN.
  - It saturates at 255.
  - It is cleared only by Reset.
- When undefined:
  - Err_Cnt is tied to 8'd0 and no counter flops are inferred.
  - Sel_Err behaviour is unchanged.

Test Plan:
1. Basic pass-through. N_IN=4, DATA_W=32, In_Bus = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, Sel=2, In_Valid=1 for one cycle, Out_Ready=1 -> next cycle Mux_Out=0xCCCC0002 and Out_Valid=1; the cycle after that, Out_Valid=0 and Mux_Out=0.
2. Backpressure. Out_Ready=0, push Sel=0 then Sel=1 -> count=2, In_Ready=0, third beat held. Raise Out_Ready -> outputs 0xAAAA0000, 0xBBBB0001, then the third beat, in order, with no loss.
3. Steady streaming. In_Valid=1 and Out_Ready=1 for 8 cycles, Sel cycling 0..3 -> one beat out per cycle, In_Ready constantly 1, output sequence matches input sequence delayed by 1 cycle.
4. Out-of-range select. N_IN=3, SEL_W=2, Sel=3 accepted -> Mux_Out=0 with Out_Valid=1 and Sel_Err=1. Sel_Err stays 1 after 10 further valid beats.
   - With MUX_ERR_CNT_EN: 300 such beats -> Err_Cnt = 255.
   - Without MUX_ERR_CNT_EN: Err_Cnt = 0.
5. Flush. Buffer full; assert Flush together with In_Valid=1 and Out_Ready=1 -> next cycle count=0, Out_Valid=0, In_Ready=1, and neither beat appears on the output.
6. Reset. Assert Reset for 1 cycle with 2 beats buffered -> In_Ready=0 during Reset; afterwards Out_Valid=0, Mux_Out=0, Sel_Err=0, Err_Cnt=0.

Source files
------------

// File: rtl/pipe_mux_n_to_1.sv
// pipe_mux_n_to_1
//   N_IN-way DATA_W-bit selector that feeds a registered 2-entry skid buffer.
//   Both sides use a valid/ready handshake. An out-of-range select writes a
//   defined zero and sets a sticky error flag.
//
//   Optional feature macro: MUX_ERR_CNT_EN
//     defined   -> Err_Cnt is a saturating (255) count of accepted
//                  out-of-range selects, cleared only by Reset.
//     undefined -> Err_Cnt is tied to zero and no counter state exists.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high reset
//   In_Bus     in   packed inputs; input k is [k*DATA_W +: DATA_W]
//   Sel        in   input index, used only on an accepted beat
//   In_Valid   in   upstream beat present
//   In_Ready   out  buffer can take a beat this cycle (registered state only)
//   Flush      in   discard all buffered beats
//   Mux_Out    out  head-of-buffer data, zero when empty
//   Out_Valid  out  Mux_Out holds a valid beat
//   Out_Ready  in   downstream takes the head beat
//   Sel_Err    out  sticky: an out-of-range Sel was accepted
//   Err_Cnt    out  count of accepted out-of-range selects
module pipe_mux_n_to_1 #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [DATA_W*N_IN-1:0]   In_Bus,
    input  logic [SEL_W-1:0]         Sel,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic                     Flush,
    output logic [DATA_W-1:0]        Mux_Out,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Sel_Err,
    output logic [7:0]               Err_Cnt
);

    if (N_IN < 2 || N_IN > 16 || (2 ** SEL_W) < N_IN) begin : g_param_check
        $error("pipe_mux_n_to_1: need 2 <= N_IN <= 16 and 2**SEL_W >= N_IN");
    end

    logic [DATA_W-1:0] buf_data_p1 [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              sel_err;

    logic [31:0]       sel_ext;
    logic              sel_oob;
    logic [DATA_W-1:0] mux_data_p0;
    logic              push;
    logic              pop;

    // Stage p0: combinational select of the incoming beat
    assign sel_ext = 32'(Sel);
    assign sel_oob = (sel_ext >= 32'(N_IN));

    always_comb begin
        mux_data_p0 = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_ext == 32'(k)) begin
                mux_data_p0 = In_Bus[k*DATA_W +: DATA_W];
            end
        end
    end

    // Flush suppresses both handshakes so a same-cycle beat is simply lost.
    assign In_Ready  = !Reset && (count != 2'd2);
    assign Out_Valid = (count != 2'd0);
    assign push      = In_Valid && In_Ready && !Flush;
    assign pop       = Out_Valid && Out_Ready && !Flush;

    // Stage p1: buffer storage (data carries no reset; validity is count)
    always_ff @(posedge Clk) begin
        if (push) begin
            buf_data_p1[wr_ptr] <= mux_data_p0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            sel_err <= 1'b0;
        end else begin
            if (Flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                if (push && !pop) begin
                    count <= count + 2'd1;
                end else if (pop && !push) begin
                    count <= count - 2'd1;
                end
            end
            if (push && sel_oob) begin
                sel_err <= 1'b1;
            end
        end
    end

`ifdef MUX_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_cnt <= 8'd0;
        end else if (push && sel_oob && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign Err_Cnt = err_cnt;
`else
    assign Err_Cnt = 8'd0;
`endif

    // Stage p2: output presentation, forced to zero when empty
    assign Mux_Out = Out_Valid ? buf_data_p1[rd_ptr] : '0;
    assign Sel_Err = sel_err;

endmodule

// File: tb/tb_pipe_mux_n_to_1.sv
module tb_pipe_mux_n_to_1;

    localparam int DW = 32;

    logic clk;

    // 4-input instance
    logic            rst4, iv4, ir4, fl4, ov4, or4, se4;
    logic [DW*4-1:0] bus4;
    logic [1:0]      sel4;
    logic [DW-1:0]   mo4;
    logic [7:0]      ec4;

    // 3-input instance (out-of-range select tests)
    logic            rst3, iv3, ir3, fl3, ov3, or3, se3;
    logic [DW*3-1:0] bus3;
    logic [1:0]      sel3;
    logic [DW-1:0]   mo3;
    logic [7:0]      ec3;

    int total = 0;
    int bad   = 0;

    pipe_mux_n_to_1 #(.DATA_W(DW), .N_IN(4), .SEL_W(2)) u_dut4 (
        .Clk(clk), .Reset(rst4), .In_Bus(bus4), .Sel(sel4), .In_Valid(iv4),
        .In_Ready(ir4), .Flush(fl4), .Mux_Out(mo4), .Out_Valid(ov4),
        .Out_Ready(or4), .Sel_Err(se4), .Err_Cnt(ec4)
    );

    pipe_mux_n_to_1 #(.DATA_W(DW), .N_IN(3), .SEL_W(2)) u_dut3 (
        .Clk(clk), .Reset(rst3), .In_Bus(bus3), .Sel(sel3), .In_Valid(iv3),
        .In_Ready(ir3), .Flush(fl3), .Mux_Out(mo3), .Out_Valid(ov3),
        .Out_Ready(or3), .Sel_Err(se3), .Err_Cnt(ec3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] mo;
        logic        ir;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic ordy,
                                input logic fl, input logic ov, input logic [31:0] mo,
                                input logic ir);
        vec_t v;
        v.iv = iv; v.sel = sel; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.mo = mo; v.ir = ir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] W0 = 32'hAAAA0000;
    localparam logic [31:0] W1 = 32'hBBBB0001;
    localparam logic [31:0] W2 = 32'hCCCC0002;
    localparam logic [31:0] W3 = 32'hDDDD0003;

`ifdef MUX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [31:0] q[$];
    logic [31:0] words[4];
    logic [31:0] w3[3];
    logic        mdl_push, mdl_pop;

    initial begin
        // columns: In_Valid, Sel, Out_Ready, Flush | Out_Valid, Mux_Out, In_Ready after the edge
        tbl[0]  = mk(1, 2, 1, 0, 1, W2, 1);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0,  1);
        tbl[2]  = mk(1, 0, 0, 0, 1, W0, 1);
        tbl[3]  = mk(1, 1, 0, 0, 1, W0, 0);
        tbl[4]  = mk(1, 3, 0, 0, 1, W0, 0);
        tbl[5]  = mk(1, 3, 1, 0, 1, W1, 1);
        tbl[6]  = mk(1, 3, 1, 0, 1, W3, 1);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0,  1);
        tbl[8]  = mk(1, 0, 1, 0, 1, W0, 1);
        tbl[9]  = mk(1, 1, 1, 0, 1, W1, 1);
        tbl[10] = mk(1, 2, 1, 0, 1, W2, 1);
        tbl[11] = mk(1, 3, 1, 0, 1, W3, 1);
        tbl[12] = mk(1, 0, 1, 0, 1, W0, 1);
        tbl[13] = mk(1, 1, 1, 0, 1, W1, 1);
        tbl[14] = mk(1, 2, 1, 0, 1, W2, 1);
        tbl[15] = mk(1, 3, 1, 0, 1, W3, 1);
        tbl[16] = mk(0, 0, 1, 0, 0, 0,  1);
        tbl[17] = mk(1, 0, 0, 0, 1, W0, 1);
        tbl[18] = mk(1, 1, 0, 0, 1, W0, 0);
        tbl[19] = mk(1, 2, 1, 1, 0, 0,  1);
        tbl[20] = mk(0, 0, 1, 0, 0, 0,  1);

        w3[0] = W0; w3[1] = W1; w3[2] = W2;

        rst4 = 1; iv4 = 0; fl4 = 0; or4 = 0; sel4 = 0; bus4 = {W3, W2, W1, W0};
        rst3 = 1; iv3 = 0; fl3 = 0; or3 = 0; sel3 = 0; bus3 = {W2, W1, W0};

        // reset state
        #1;
        check("rst_in_ready", {31'd0, ir4}, 0);
        step(); step();
        check("rst_in_ready_held", {31'd0, ir4}, 0);
        check("rst_out_valid", {31'd0, ov4}, 0);
        check("rst_mux_out", mo4, 0);
        check("rst_sel_err", {31'd0, se4}, 0);
        check("rst_err_cnt", {24'd0, ec4}, 0);
        rst4 = 0; rst3 = 0;
        #1;
        check("post_rst_in_ready", {31'd0, ir4}, 1);

        // table-driven sequences: pass-through, backpressure, streaming, flush
        for (int i = 0; i < 21; i++) begin
            iv4 = tbl[i].iv; sel4 = tbl[i].sel; or4 = tbl[i].ordy; fl4 = tbl[i].fl;
            step();
            check($sformatf("vec%0d_out_valid", i), {31'd0, ov4}, {31'd0, tbl[i].ov});
            check($sformatf("vec%0d_mux_out", i), mo4, tbl[i].mo);
            check($sformatf("vec%0d_in_ready", i), {31'd0, ir4}, {31'd0, tbl[i].ir});
        end
        iv4 = 0; fl4 = 0;

        // randomized traffic against a queue model
        q.delete();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            bus4 = {words[3], words[2], words[1], words[0]};
            sel4 = 2'($urandom_range(0, 3));
            iv4  = ($urandom_range(0, 3) != 0);
            or4  = ($urandom_range(0, 2) != 0);
            fl4  = ($urandom_range(0, 19) == 0);
            #1;
            check("rnd_out_valid", {31'd0, ov4}, (q.size() != 0) ? 1 : 0);
            check("rnd_mux_out", mo4, (q.size() != 0) ? q[0] : 32'd0);
            check("rnd_in_ready", {31'd0, ir4}, (q.size() != 2) ? 1 : 0);
            mdl_push = iv4 && (q.size() < 2) && !fl4;
            mdl_pop  = or4 && (q.size() > 0) && !fl4;
            if (fl4) begin
                q.delete();
            end else begin
                if (mdl_pop) void'(q.pop_front());
                if (mdl_push) q.push_back(words[sel4]);
            end
            step();
        end
        iv4 = 0; fl4 = 0;
        check("rnd_sel_err_clear", {31'd0, se4}, 0);

        // out-of-range select on the 3-input instance
        iv3 = 1; or3 = 1; sel3 = 3;
        step();
        check("oob_out_valid", {31'd0, ov3}, 1);
        check("oob_mux_out", mo3, 0);
        check("oob_sel_err", {31'd0, se3}, 1);
        check("oob_err_cnt_first", {24'd0, ec3}, CNT_EN ? 1 : 0);
        for (int i = 0; i < 10; i++) begin
            sel3 = 2'(i % 3);
            step();
            check("inrange_mux_out", mo3, w3[i % 3]);
        end
        check("sel_err_sticky", {31'd0, se3}, 1);
        sel3 = 3;
        for (int i = 0; i < 300; i++) step();
        iv3 = 0;
        step();
        check("err_cnt_sat", {24'd0, ec3}, CNT_EN ? 255 : 0);
        check("sel_err_after_burst", {31'd0, se3}, 1);
        check("drain_out_valid", {31'd0, ov3}, 0);

        // reset mid-transfer with two beats buffered
        or3 = 0; iv3 = 1; sel3 = 0;
        step();
        sel3 = 1;
        step();
        check("full_in_ready", {31'd0, ir3}, 0);
        check("full_head", mo3, W0);
        rst3 = 1;
        #1;
        check("mid_rst_in_ready", {31'd0, ir3}, 0);
        step();
        rst3 = 0; iv3 = 0; or3 = 1;
        #1;
        check("mid_rst_out_valid", {31'd0, ov3}, 0);
        check("mid_rst_mux_out", mo3, 0);
        check("mid_rst_sel_err", {31'd0, se3}, 0);
        check("mid_rst_err_cnt", {24'd0, ec3}, 0);
        check("mid_rst_in_ready_after", {31'd0, ir3}, 1);
        step();
        check("mid_rst_no_beat", {31'd0, ov3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
